csa_mult_reduce: RTL

CSA_MULT_REDUCE -- requirements
Module: csa_mult_reduce

---
 rtl/csa_mult_reduce.sv | 99 +++++++++
 1 files changed

// File: rtl/csa_mult_reduce.sv
// Serial shift-and-add multiplier that leaves X*Y as two carry-save rows A/B for a downstream adder.
// Optional build macro CSA_ZERO_SKIP_EN: stop accumulating once no multiplier bits remain.
module csa_mult_reduce #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] A,
    output logic [2*WIDTH-1:0] B
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_xreg;
    logic [WIDTH-1:0] r_yreg;
    logic [CW-1:0]    r_cnt;
    logic [RW-1:0]    r_a;
    logic [RW-1:0]    r_b;

    logic [RW-1:0]    w_pp;
    logic [RW-1:0]    w_sum;
    logic [RW-1:0]    w_carry;
    logic             w_last;

    // Handshakes: a pair is taken on a rising edge with in_valid && in_ready,
    // and rows are consumed on a rising edge with out_valid && out_ready.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign A         = r_a;
    assign B         = r_b;

    // One full-adder row folds the current partial product into the carry-save pair.
    assign w_pp    = r_yreg[0] ? ({{WIDTH{1'b0}}, r_xreg} << r_cnt) : '0;
    assign w_sum   = r_a ^ r_b ^ w_pp;
    assign w_carry = ((r_a & r_b) | (r_a & w_pp) | (r_b & w_pp)) << 1;

`ifdef CSA_ZERO_SKIP_EN
    assign w_last = (r_cnt == LAST) || ((r_yreg >> 1) == '0);
`else
    assign w_last = (r_cnt == LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_xreg  <= '0;
            r_yreg  <= '0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_xreg  <= X;
                        r_yreg  <= Y;
                        r_cnt   <= '0;
                        r_a     <= '0;
                        r_b     <= '0;
                        r_state <= ACC;
                    end
                end
                ACC: begin
                    r_a     <= w_sum;
                    r_b     <= w_carry;
                    r_yreg  <= r_yreg >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // Rows stay frozen until the downstream stage takes them.
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
